// File: rtl/types_pkg.sv
// Shared pipeline types plus the memory-stage state, funct3 encodings and
// the alignment/lane helpers used by the MEM stage.
package types_pkg;

    typedef logic [63:0] dword_t;
    typedef logic [4:0]  reg_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Stores only exist for sizes B/H/W/D, so the unsigned encodings count as bad stores.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic       is_store,
                                           input logic [2:0] offset);
        logic [2:0] mask;
        case (funct3)
            F3_B, F3_BU: mask = 3'b000;
            F3_H, F3_HU: mask = 3'b001;
            F3_W, F3_WU: mask = 3'b011;
            F3_D:        mask = 3'b111;
            default:     mask = 3'b000;
        endcase
        return (funct3 == 3'b111) || (is_store && funct3[2]) || ((offset & mask) != 3'b000);
    endfunction

    function automatic logic [7:0] store_lanes(input logic [1:0] size,
                                               input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_if;
    import types_pkg::*;

    logic       dmemREN;
    logic       dmemWEN;
    dword_t     dmemaddr;
    dword_t     dmemstore;
    logic [7:0] dmembyteen;
    logic       dhit;
    dword_t     dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dmembyteen,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, dmembyteen,
        output dhit, dmemload
    );

endinterface

// File: rtl/mem_stage_load_format.sv
// Extracts the addressed field from a loaded doubleword and sign/zero
// extends it to 64 bits according to funct3.
module mem_load_format
    import types_pkg::*;
(
    input  dword_t     dmemload,
    input  logic [2:0] offset,
    input  logic [2:0] funct3,
    output dword_t     load_ext
);

    dword_t shifted;

    always_comb begin
        shifted  = dmemload >> {offset, 3'b000};
        load_ext = '0;
        case (funct3)
            F3_B:    load_ext = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_ext = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_ext = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    load_ext = shifted;
            F3_BU:   load_ext = {56'b0, shifted[7:0]};
            F3_HU:   load_ext = {48'b0, shifted[15:0]};
            F3_WU:   load_ext = {32'b0, shifted[31:0]};
            default: load_ext = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV64 pipeline: runs the data-memory handshake for loads
// and stores and feeds the MEM/WB latch, stalling until the access completes.
module mem_stage
    import types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,

    input  logic        ex_valid,
    input  logic        RegWrite_ex,
    input  logic        MemToReg_ex,
    input  logic        MemRead_ex,
    input  logic        MemWrite_ex,
    input  logic [2:0]  funct3_ex,
    input  reg_t        rd_ex,
    input  dword_t      aluout_ex,
    input  dword_t      storedata_ex,

    mem_stage_if.master dmem,

    output logic        RegWrite_mem,
    output logic        MemToReg_mem,
    output reg_t        rd_mem,
    output dword_t      dmemdata_mem,
    output dword_t      aluout_mem,
    output logic        mem_stall,
    output logic        misaligned_mem
);

    mem_state_t state;

    reg_t       lat_rd;
    logic       lat_regwrite;
    logic       lat_load;
    logic       lat_store;
    logic [2:0] lat_funct3;
    dword_t     lat_addr;
    dword_t     lat_store_data;
    logic [7:0] lat_byteen;
    dword_t     load_data;
    dword_t     load_fmt;

    logic is_mem_op;
    logic ex_misaligned;
    logic accept;

    // MemToReg for loads is implied by MemRead, so the EX copy is not needed.
    logic unused_memtoreg;
    assign unused_memtoreg = MemToReg_ex;

    assign is_mem_op     = ex_valid && (MemRead_ex || MemWrite_ex);
    assign ex_misaligned = is_mem_op && is_misaligned(funct3_ex, MemWrite_ex, aluout_ex[2:0]);
    assign accept        = (state == IDLE) && is_mem_op && !ex_misaligned;

    mem_load_format u_load_format (
        .dmemload (dmem.dmemload),
        .offset   (lat_addr[2:0]),
        .funct3   (lat_funct3),
        .load_ext (load_fmt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            lat_rd         <= '0;
            lat_regwrite   <= 1'b0;
            lat_load       <= 1'b0;
            lat_store      <= 1'b0;
            lat_funct3     <= '0;
            lat_addr       <= '0;
            lat_store_data <= '0;
            lat_byteen     <= '0;
            load_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_rd         <= rd_ex;
                        lat_regwrite   <= RegWrite_ex;
                        lat_load       <= MemRead_ex && !MemWrite_ex;
                        lat_store      <= MemWrite_ex;
                        lat_funct3     <= funct3_ex;
                        lat_addr       <= aluout_ex;
                        lat_store_data <= storedata_ex << {aluout_ex[2:0], 3'b000};
                        lat_byteen     <= store_lanes(funct3_ex[1:0], aluout_ex[2:0]);
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (dmem.dhit) begin
                        load_data <= lat_load ? load_fmt : '0;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gating on nRST makes requests and stall fall the instant reset asserts,
    // even while EX/MEM still presents a memory op.
    always_comb begin
        dmem.dmemREN    = 1'b0;
        dmem.dmemWEN    = 1'b0;
        dmem.dmemaddr   = '0;
        dmem.dmemstore  = '0;
        dmem.dmembyteen = '0;
        RegWrite_mem    = 1'b0;
        MemToReg_mem    = 1'b0;
        rd_mem          = '0;
        dmemdata_mem    = '0;
        aluout_mem      = '0;
        mem_stall       = 1'b0;
        misaligned_mem  = 1'b0;
        if (nRST) begin
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        rd_mem     = rd_ex;
                        aluout_mem = aluout_ex;
                        if (!is_mem_op) begin
                            RegWrite_mem = RegWrite_ex;
                        end else if (ex_misaligned) begin
                            misaligned_mem = 1'b1;
                        end else begin
                            mem_stall = 1'b1;
                        end
                    end
                end
                REQ: begin
                    mem_stall       = 1'b1;
                    dmem.dmemREN    = lat_load;
                    dmem.dmemWEN    = lat_store;
                    dmem.dmemaddr   = {lat_addr[63:3], 3'b000};
                    dmem.dmemstore  = lat_store ? lat_store_data : '0;
                    dmem.dmembyteen = lat_store ? lat_byteen : '0;
                    rd_mem          = lat_rd;
                    aluout_mem      = lat_addr;
                end
                DONE: begin
                    RegWrite_mem = lat_regwrite && lat_load;
                    MemToReg_mem = lat_load;
                    rd_mem       = lat_rd;
                    aluout_mem   = lat_addr;
                    dmemdata_mem = load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, an asynchronous
// reset abort during REQ, then random ops checked against a byte-level model.
module tb_mem_stage;
    import types_pkg::*;

    typedef struct {
        logic        valid;
        logic        rd_en;
        logic        wr_en;
        logic        regw;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] ldata;
        int          delay;
        logic        e_mis;
        logic [63:0] e_maddr;
        logic [7:0]  e_ben;
        logic [63:0] e_store;
        logic [63:0] e_data;
        logic        e_regw;
    } vec_t;

    logic   CLK;
    logic   nRST;
    logic   ex_valid, RegWrite_ex, MemToReg_ex, MemRead_ex, MemWrite_ex;
    logic [2:0] funct3_ex;
    reg_t   rd_ex;
    dword_t aluout_ex, storedata_ex;
    logic   RegWrite_mem, MemToReg_mem, mem_stall, misaligned_mem;
    reg_t   rd_mem;
    dword_t dmemdata_mem, aluout_mem;

    int checks = 0;
    int errors = 0;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ex_valid     (ex_valid),
        .RegWrite_ex  (RegWrite_ex),
        .MemToReg_ex  (MemToReg_ex),
        .MemRead_ex   (MemRead_ex),
        .MemWrite_ex  (MemWrite_ex),
        .funct3_ex    (funct3_ex),
        .rd_ex        (rd_ex),
        .aluout_ex    (aluout_ex),
        .storedata_ex (storedata_ex),
        .dmem         (dmem_bus),
        .RegWrite_mem (RegWrite_mem),
        .MemToReg_mem (MemToReg_mem),
        .rd_mem       (rd_mem),
        .dmemdata_mem (dmemdata_mem),
        .aluout_mem   (aluout_mem),
        .mem_stall    (mem_stall),
        .misaligned_mem (misaligned_mem)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int nbytesOf(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    // Reference model: works byte by byte from the access size and address.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          nb;
        int          off;
        logic        memop;
        logic [63:0] field;
        r     = v;
        nb    = nbytesOf(v.f3);
        off   = int'(v.addr % 64'd8);
        memop = v.valid && (v.rd_en || v.wr_en);
        r.e_mis   = memop && ((v.f3 == 3'd7) || (v.wr_en && v.f3 > 3'd3) || ((v.addr % 64'(nb)) != 64'd0));
        r.e_maddr = v.addr - 64'(off);
        r.e_ben   = '0;
        r.e_store = '0;
        r.e_data  = '0;
        if (v.wr_en && !r.e_mis) begin
            for (int i = 0; i < nb; i++) r.e_ben[off + i] = 1'b1;
            r.e_store = v.sdata << (8 * off);
        end
        if (v.rd_en && !r.e_mis) begin
            field = '0;
            for (int i = 0; i < nb; i++) field[8*i +: 8] = v.ldata[8*(off + i) +: 8];
            if (v.f3 < 3'd4 && field[8*nb - 1]) begin
                for (int i = nb; i < 8; i++) field[8*i +: 8] = 8'hFF;
            end
            r.e_data = field;
        end
        r.e_regw = v.valid && !r.e_mis && v.regw && !v.wr_en;
        return r;
    endfunction

    function automatic vec_t randOp();
        vec_t v;
        int   kind;
        v = '{default: 0};
        kind    = int'($urandom_range(0, 3));
        v.valid = (kind != 3);
        v.rd_en = (kind == 0) || (kind == 3 && $urandom_range(0, 1) == 1);
        v.wr_en = (kind == 1);
        v.regw  = 1'($urandom_range(0, 1));
        v.f3    = (kind == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        v.rd    = 5'($urandom);
        v.addr  = {32'h0, $urandom};
        if ($urandom_range(0, 3) != 0) v.addr = v.addr - (v.addr % 64'(nbytesOf(v.f3)));
        v.sdata = {$urandom, $urandom};
        v.ldata = {$urandom, $urandom};
        v.delay = int'($urandom_range(0, 3));
        return model(v);
    endfunction

    // Entered #1 after a rising edge; leaves #1 after the rising edge that ends the op.
    task automatic applyStimulus(input vec_t v, input string tag);
        int   req_cycles;
        int   stall_cycles;
        logic memop;
        ex_valid     = v.valid;
        RegWrite_ex  = v.regw;
        MemRead_ex   = v.rd_en;
        MemWrite_ex  = v.wr_en;
        MemToReg_ex  = v.rd_en;
        funct3_ex    = v.f3;
        rd_ex        = v.rd;
        aluout_ex    = v.addr;
        storedata_ex = v.sdata;
        dmem_bus.dhit     = 1'($urandom_range(0, 1));
        dmem_bus.dmemload = {$urandom, $urandom};
        memop = v.valid && (v.rd_en || v.wr_en);
        @(negedge CLK);
        if (!memop || v.e_mis) begin
            checkBit({tag, " stall"}, mem_stall, 1'b0);
            checkBit({tag, " misaligned"}, misaligned_mem, v.e_mis);
            checkBit({tag, " ren"}, dmem_bus.dmemREN, 1'b0);
            checkBit({tag, " wen"}, dmem_bus.dmemWEN, 1'b0);
            checkBit({tag, " regwrite"}, RegWrite_mem, v.e_regw);
            checkBit({tag, " memtoreg"}, MemToReg_mem, 1'b0);
            if (v.valid && !memop) begin
                checkOutput({tag, " aluout"}, aluout_mem, v.addr);
                checkOutput({tag, " rd"}, 64'(rd_mem), 64'(v.rd));
            end
            @(posedge CLK);
            #1;
            return;
        end
        checkBit({tag, " accept stall"}, mem_stall, 1'b1);
        checkBit({tag, " accept regwrite"}, RegWrite_mem, 1'b0);
        checkBit({tag, " accept misaligned"}, misaligned_mem, 1'b0);
        checkBit({tag, " accept req"}, dmem_bus.dmemREN | dmem_bus.dmemWEN, 1'b0);
        stall_cycles = int'(mem_stall);
        req_cycles   = 0;
        @(posedge CLK);
        #1;
        for (int k = 0; k <= v.delay; k++) begin
            dmem_bus.dhit     = (k == v.delay);
            dmem_bus.dmemload = (k == v.delay) ? v.ldata : {$urandom, $urandom};
            @(negedge CLK);
            if (dmem_bus.dmemREN || dmem_bus.dmemWEN) req_cycles++;
            if (mem_stall) stall_cycles++;
            checkBit({tag, " req ren"}, dmem_bus.dmemREN, v.rd_en);
            checkBit({tag, " req wen"}, dmem_bus.dmemWEN, v.wr_en);
            checkOutput({tag, " req addr"}, dmem_bus.dmemaddr, v.e_maddr);
            if (v.wr_en) begin
                checkOutput({tag, " req byteen"}, 64'(dmem_bus.dmembyteen), 64'(v.e_ben));
                checkOutput({tag, " req store"}, dmem_bus.dmemstore, v.e_store);
            end
            @(posedge CLK);
            #1;
        end
        dmem_bus.dhit     = 1'($urandom_range(0, 1));
        dmem_bus.dmemload = {$urandom, $urandom};
        @(negedge CLK);
        if (mem_stall) stall_cycles++;
        checkBit({tag, " done stall"}, mem_stall, 1'b0);
        checkBit({tag, " done req"}, dmem_bus.dmemREN | dmem_bus.dmemWEN, 1'b0);
        checkBit({tag, " done regwrite"}, RegWrite_mem, v.e_regw);
        checkBit({tag, " done memtoreg"}, MemToReg_mem, v.rd_en);
        checkOutput({tag, " done rd"}, 64'(rd_mem), 64'(v.rd));
        if (v.rd_en) checkOutput({tag, " done data"}, dmemdata_mem, v.e_data);
        checkOutput({tag, " req cycles"}, 64'(req_cycles), 64'(v.delay + 1));
        checkOutput({tag, " stall cycles"}, 64'(stall_cycles), 64'(v.delay + 2));
        @(posedge CLK);
        #1;
    endtask

    vec_t dir [18];

    initial begin
        // valid rd wr regw f3 rd addr sdata ldata delay | mis maddr ben store data regw
        dir[0]  = '{1, 1, 0, 1, 3'd3, 5'd5,  64'h1000, 64'h0, 64'h1122334455667788, 2,
                    0, 64'h1000, 8'h00, 64'h0, 64'h1122334455667788, 1};
        dir[1]  = '{1, 1, 0, 1, 3'd0, 5'd6,  64'h1003, 64'h0, 64'h0000000080000000, 0,
                    0, 64'h1000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80, 1};
        dir[2]  = '{1, 1, 0, 1, 3'd4, 5'd6,  64'h1003, 64'h0, 64'h0000000080000000, 0,
                    0, 64'h1000, 8'h00, 64'h0, 64'h0000000000000080, 1};
        dir[3]  = '{1, 0, 1, 1, 3'd1, 5'd9,  64'h2006, 64'hABCD, 64'h0, 1,
                    0, 64'h2000, 8'hC0, 64'hABCD000000000000, 64'h0, 0};
        dir[4]  = '{1, 1, 0, 1, 3'd2, 5'd10, 64'h3002, 64'h0, 64'h0, 0,
                    1, 64'h3000, 8'h00, 64'h0, 64'h0, 0};
        dir[5]  = '{1, 0, 0, 1, 3'd0, 5'd7,  64'h55, 64'h0, 64'h0, 0,
                    0, 64'h50, 8'h00, 64'h0, 64'h0, 1};
        dir[6]  = '{0, 1, 0, 1, 3'd3, 5'd3,  64'h99, 64'h0, 64'h0, 0,
                    0, 64'h98, 8'h00, 64'h0, 64'h0, 0};
        dir[7]  = '{1, 0, 1, 0, 3'd3, 5'd11, 64'h5008, 64'h0102030405060708, 64'h0, 3,
                    0, 64'h5008, 8'hFF, 64'h0102030405060708, 64'h0, 0};
        dir[8]  = '{1, 1, 0, 1, 3'd3, 5'd12, 64'h4004, 64'h0, 64'h0, 0,
                    1, 64'h4000, 8'h00, 64'h0, 64'h0, 0};
        dir[9]  = '{1, 1, 0, 1, 3'd7, 5'd13, 64'h6000, 64'h0, 64'h0, 0,
                    1, 64'h6000, 8'h00, 64'h0, 64'h0, 0};
        dir[10] = '{1, 1, 0, 1, 3'd1, 5'd14, 64'h7002, 64'h0, 64'h00000000F00D0000, 1,
                    0, 64'h7000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFF00D, 1};
        dir[11] = '{1, 1, 0, 1, 3'd2, 5'd15, 64'h7004, 64'h0, 64'h89ABCDEF00000000, 0,
                    0, 64'h7000, 8'h00, 64'h0, 64'hFFFFFFFF89ABCDEF, 1};
        dir[12] = '{1, 1, 0, 1, 3'd6, 5'd16, 64'h7004, 64'h0, 64'h89ABCDEF00000000, 0,
                    0, 64'h7000, 8'h00, 64'h0, 64'h0000000089ABCDEF, 1};
        dir[13] = '{1, 0, 1, 1, 3'd0, 5'd17, 64'h8005, 64'h5A, 64'h0, 0,
                    0, 64'h8000, 8'h20, 64'h00005A0000000000, 64'h0, 0};
        dir[14] = '{1, 0, 1, 0, 3'd2, 5'd18, 64'h9004, 64'hDEADBEEF, 64'h0, 2,
                    0, 64'h9000, 8'hF0, 64'hDEADBEEF00000000, 64'h0, 0};
        dir[15] = '{1, 1, 0, 1, 3'd5, 5'd19, 64'h7006, 64'h0, 64'h8001000000000000, 0,
                    0, 64'h7000, 8'h00, 64'h0, 64'h0000000000008001, 1};
        dir[16] = '{1, 0, 1, 1, 3'd1, 5'd20, 64'hA001, 64'h1234, 64'h0, 0,
                    1, 64'hA000, 8'h00, 64'h0, 64'h0, 0};
        dir[17] = '{1, 1, 0, 0, 3'd3, 5'd21, 64'hB000, 64'h0, 64'h000000000000CAFE, 1,
                    0, 64'hB000, 8'h00, 64'h0, 64'h000000000000CAFE, 0};

        nRST         = 1'b0;
        ex_valid     = 1'b1;
        RegWrite_ex  = 1'b1;
        MemToReg_ex  = 1'b0;
        MemRead_ex   = 1'b0;
        MemWrite_ex  = 1'b0;
        funct3_ex    = 3'd0;
        rd_ex        = 5'd7;
        aluout_ex    = 64'h55;
        storedata_ex = 64'h1234;
        dmem_bus.dhit     = 1'b1;
        dmem_bus.dmemload = 64'hFFFF;
        #1;
        checkBit("reset ren", dmem_bus.dmemREN, 1'b0);
        checkBit("reset wen", dmem_bus.dmemWEN, 1'b0);
        checkBit("reset stall", mem_stall, 1'b0);
        checkBit("reset misaligned", misaligned_mem, 1'b0);
        checkBit("reset regwrite", RegWrite_mem, 1'b0);
        checkBit("reset memtoreg", MemToReg_mem, 1'b0);
        checkOutput("reset byteen", 64'(dmem_bus.dmembyteen), 64'h0);
        checkOutput("reset addr", dmem_bus.dmemaddr, 64'h0);
        checkOutput("reset store", dmem_bus.dmemstore, 64'h0);
        checkOutput("reset data", dmemdata_mem, 64'h0);
        checkOutput("reset aluout", aluout_mem, 64'h0);
        checkOutput("reset rd", 64'(rd_mem), 64'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        dmem_bus.dhit = 1'b0;

        for (int i = 0; i < 18; i++) applyStimulus(dir[i], $sformatf("dir%0d", i));

        // Abort an LD mid-REQ with an asynchronous reset, then rerun it.
        ex_valid     = 1'b1;
        RegWrite_ex  = 1'b1;
        MemRead_ex   = 1'b1;
        MemWrite_ex  = 1'b0;
        MemToReg_ex  = 1'b1;
        funct3_ex    = 3'd3;
        rd_ex        = 5'd5;
        aluout_ex    = 64'h1000;
        dmem_bus.dhit = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkBit("abort req ren", dmem_bus.dmemREN, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        checkBit("abort ren", dmem_bus.dmemREN, 1'b0);
        checkBit("abort wen", dmem_bus.dmemWEN, 1'b0);
        checkBit("abort stall", mem_stall, 1'b0);
        ex_valid = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(negedge CLK);
        checkBit("abort idle ren", dmem_bus.dmemREN, 1'b0);
        checkBit("abort idle stall", mem_stall, 1'b0);
        @(posedge CLK);
        #1;
        applyStimulus(dir[0], "after abort");

        for (int i = 0; i < 40; i++) applyStimulus(randOp(), $sformatf("rand%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
